lcd_result_writer: RTL and testbench

Drives the HD44780-compatible character LCD from the exponent FSMD result. It initialises the panel after reset, then converts each new 16-bit result to five ASCII decimal digits and writes them to line 1. It sits beside the control unit and datapath in the top level, consuming `output_reg`/`sig_done` and producing the `LCD_*` pins.

---
 rtl/lcd_result_writer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_lcd_result_writer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_result_writer.sv
// HD44780 result writer: powers up and initialises the panel, then shows each new
// 16-bit result as five ASCII decimal digits on line 1 via iterative double-dabble.
module lcd_result_writer #(
  parameter int EN_HIGH_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000,
  parameter int INIT_WAIT_CYC  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] result_i,
  input  logic        valid_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_EN,
  output logic        LCD_RW,
  output logic        LCD_RS,
  output logic        LCD_ON,
  output logic        LCD_BLON
);

  localparam int MAX_A = (INIT_WAIT_CYC > CLEAR_WAIT_CYC) ? INIT_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int MAX_B = (CMD_WAIT_CYC > EN_HIGH_CYC) ? CMD_WAIT_CYC : EN_HIGH_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_INIT_CMD,
    S_IDLE,
    S_CONVERT,
    S_WR_ADDR,
    S_WR_DIGIT
  } state_t;

  typedef enum logic [2:0] {
    PH_OFF,
    PH_SETUP,
    PH_EN,
    PH_HOLD,
    PH_WAIT
  } phase_t;

  state_t        state_q, state_d;
  phase_t        ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [4:0]    bit_q, bit_d;
  logic [15:0]   sh_q, sh_d;
  logic [19:0]   bcd_q, bcd_d;
  logic [15:0]   val_q, val_d;
  logic          pend_q, pend_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          en_q, en_d;
  logic          on_q;
  logic          done_q, done_d;

  logic          byte_done;
  logic          init_done;
  logic          conv_done;
  logic [CW-1:0] wait_len;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    logic [7:0] c;
    case (i)
      3'd0:    c = 8'h38;
      3'd1:    c = 8'h0C;
      3'd2:    c = 8'h01;
      default: c = 8'h06;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] digit_char(input logic [19:0] bcd, input logic [2:0] i);
    logic [3:0] d;
    case (i)
      3'd0:    d = bcd[19:16];
      3'd1:    d = bcd[15:12];
      3'd2:    d = bcd[11:8];
      3'd3:    d = bcd[7:4];
      default: d = bcd[3:0];
    endcase
    return {4'h3, d};
  endfunction

  // One double-dabble step: correct every BCD nibble >= 5, then shift {bcd, bin} left.
  function automatic logic [35:0] dabble_step(input logic [19:0] bcd, input logic [15:0] bin);
    logic [19:0] adj;
    adj = bcd;
    for (int k = 0; k < 5; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
    return {adj[18:0], bin, 1'b0};
  endfunction

  assign byte_done = (ph_q == PH_WAIT) && (cnt_q == '0);
  assign init_done = (state_q == S_INIT_WAIT) && (cnt_q == CW'(INIT_WAIT_CYC - 1));
  assign conv_done = (state_q == S_CONVERT) && (bit_q == 5'd17);
  assign wait_len  = ((state_q == S_INIT_CMD) && (idx_q == 3'd2)) ?
                     CW'(CLEAR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT_WAIT;
      ph_q       <= PH_OFF;
      cnt_q      <= '0;
      idx_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      bcd_q      <= '0;
      val_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      data_q     <= '0;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
      on_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      bcd_q      <= bcd_d;
      val_q      <= val_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      en_q       <= en_d;
      on_q       <= 1'b1;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT_WAIT: if (init_done) state_d = S_INIT_CMD;
      S_INIT_CMD:  if (byte_done && (idx_q == 3'd3)) state_d = S_IDLE;
      S_IDLE:      if (valid_i || pend_q) state_d = S_CONVERT;
      S_CONVERT:   if (conv_done) state_d = S_WR_ADDR;
      S_WR_ADDR:   if (byte_done) state_d = S_WR_DIGIT;
      S_WR_DIGIT:  if (byte_done && (idx_q == 3'd4)) state_d = S_IDLE;
      default:     state_d = S_INIT_WAIT;
    endcase
  end

  always_comb begin
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    bcd_d      = bcd_q;
    val_d      = val_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    data_d     = data_q;
    rs_d       = rs_q;
    en_d       = en_q;
    done_d     = 1'b0;

    // Byte strobe sequencing: SETUP -> EN high -> HOLD -> post-byte wait.
    case (ph_q)
      PH_SETUP: begin
        en_d  = 1'b1;
        ph_d  = PH_EN;
        cnt_d = CW'(EN_HIGH_CYC - 1);
      end
      PH_EN: begin
        if (cnt_q == '0) begin
          en_d = 1'b0;
          ph_d = PH_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PH_HOLD: begin
        ph_d  = PH_WAIT;
        cnt_d = wait_len;
      end
      PH_WAIT: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      default: ;
    endcase

    case (state_q)
      S_INIT_WAIT: begin
        if (init_done) begin
          idx_d  = 3'd0;
          data_d = init_cmd(3'd0);
          rs_d   = 1'b0;
          ph_d   = PH_SETUP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_INIT_CMD: begin
        if (byte_done) begin
          if (idx_q == 3'd3) begin
            ph_d = PH_OFF;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = init_cmd(idx_q + 3'd1);
            rs_d   = 1'b0;
            ph_d   = PH_SETUP;
          end
        end
      end
      S_IDLE: begin
        // A fresh valid_i beats the stored pending value.
        if (valid_i) begin
          val_d  = result_i;
          pend_d = 1'b0;
          bit_d  = 5'd0;
        end else if (pend_q) begin
          val_d  = pend_val_q;
          pend_d = 1'b0;
          bit_d  = 5'd0;
        end
      end
      S_CONVERT: begin
        if (bit_q == 5'd0) begin
          sh_d  = val_q;
          bcd_d = '0;
          bit_d = 5'd1;
        end else if (bit_q != 5'd17) begin
          {bcd_d, sh_d} = dabble_step(bcd_q, sh_q);
          bit_d         = bit_q + 5'd1;
        end else begin
          data_d = 8'h80;
          rs_d   = 1'b0;
          ph_d   = PH_SETUP;
        end
      end
      S_WR_ADDR: begin
        if (byte_done) begin
          idx_d  = 3'd0;
          data_d = digit_char(bcd_q, 3'd0);
          rs_d   = 1'b1;
          ph_d   = PH_SETUP;
        end
      end
      S_WR_DIGIT: begin
        if (byte_done) begin
          if (idx_q == 3'd4) begin
            ph_d   = PH_OFF;
            done_d = 1'b1;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = digit_char(bcd_q, idx_q + 3'd1);
            rs_d   = 1'b1;
            ph_d   = PH_SETUP;
          end
        end
      end
      default: ;
    endcase

    if ((state_q != S_IDLE) && valid_i) begin
      pend_d     = 1'b1;
      pend_val_d = result_i;
    end
  end

  always_comb begin
    busy_o   = (state_q != S_IDLE);
    done_o   = done_q;
    LCD_DATA = data_q;
    LCD_EN   = en_q;
    LCD_RW   = 1'b0;
    LCD_RS   = rs_q;
    LCD_ON   = on_q;
    LCD_BLON = on_q;
  end

endmodule

// File: tb/tb_lcd_result_writer.sv
// Self-checking bench for lcd_result_writer: a scoreboard of expected LCD bytes is
// compared on every LCD_EN falling edge, with table-driven refreshes and corner sequences.
module tb_lcd_result_writer;

  logic        clk;
  logic        rst;
  logic [15:0] result_i;
  logic        valid_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  LCD_DATA;
  logic        LCD_EN;
  logic        LCD_RW;
  logic        LCD_RS;
  logic        LCD_ON;
  logic        LCD_BLON;

  lcd_result_writer #(
    .EN_HIGH_CYC   (2),
    .CMD_WAIT_CYC  (4),
    .CLEAR_WAIT_CYC(8),
    .INIT_WAIT_CYC (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .result_i(result_i),
    .valid_i (valid_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .LCD_DATA(LCD_DATA),
    .LCD_EN  (LCD_EN),
    .LCD_RW  (LCD_RW),
    .LCD_RS  (LCD_RS),
    .LCD_ON  (LCD_ON),
    .LCD_BLON(LCD_BLON)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [39:0] text;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] sb[$];
  int         falls[$];
  int         mon_cyc  = 0;
  int         nbytes   = 0;
  int         done_cnt = 0;
  int         high_cnt = 0;
  logic       prev_en  = 1'b0;
  logic [8:0] held     = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pushInit();
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h06});
  endtask

  task automatic pushRefresh(input logic [39:0] text);
    sb.push_back({1'b0, 8'h80});
    for (int k = 0; k < 5; k++) sb.push_back({1'b1, text[39-8*k -: 8]});
  endtask

  // Drives one valid_i cycle; returns 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic [15:0] value);
    @(negedge clk);
    result_i = value;
    valid_i  = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic waitDone(output bit got);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        got = 1'b1;
        checkOutput("busy low with done", 32'(busy_o), 32'd0);
        break;
      end
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (!busy_o) break;
    end
  endtask

  // Byte monitor: every LCD_EN fall pops one scoreboard entry.
  always @(negedge clk) begin
    mon_cyc++;
    if (!rst) begin
      prev_en  = 1'b0;
      high_cnt = 0;
    end else begin
      if (LCD_EN) begin
        if (!prev_en) begin
          held     = {LCD_RS, LCD_DATA};
          high_cnt = 1;
        end else begin
          high_cnt++;
          checkOutput("data stable while EN", 32'({LCD_RS, LCD_DATA}), 32'(held));
        end
      end else if (prev_en) begin
        checkOutput("EN high width", 32'(high_cnt), 32'd2);
        checkOutput("data held in HOLD", 32'({LCD_RS, LCD_DATA}), 32'(held));
        checkOutput("RW low", 32'(LCD_RW), 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected byte: got 0x%0h, expected none", {LCD_RS, LCD_DATA});
        end else begin
          checkOutput("lcd byte {rs,data}", 32'(held), 32'(sb.pop_front()));
        end
        falls.push_back(mon_cyc);
        nbytes++;
      end
      if (done_o) done_cnt++;
      prev_en = LCD_EN;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   d0;
    int   nb0;
    int   lat;
    bit   got;

    vecs[0] = '{16'd12345, "12345"};
    vecs[1] = '{16'd0,     "00000"};
    vecs[2] = '{16'd65535, "65535"};
    vecs[3] = '{16'd40960, "40960"};
    vecs[4] = '{16'd1,     "00001"};
    vecs[5] = '{16'd9999,  "09999"};

    rst      = 1'b0;
    valid_i  = 1'b0;
    result_i = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset LCD_DATA", 32'(LCD_DATA), 32'h00);
    checkOutput("reset LCD_EN",   32'(LCD_EN),   32'd0);
    checkOutput("reset LCD_RS",   32'(LCD_RS),   32'd0);
    checkOutput("reset LCD_RW",   32'(LCD_RW),   32'd0);
    checkOutput("reset LCD_ON",   32'(LCD_ON),   32'd0);
    checkOutput("reset LCD_BLON", 32'(LCD_BLON), 32'd0);
    checkOutput("reset busy_o",   32'(busy_o),   32'd1);
    checkOutput("reset done_o",   32'(done_o),   32'd0);

    pushInit();
    falls.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("LCD_ON after release",   32'(LCD_ON),   32'd1);
    checkOutput("LCD_BLON after release", 32'(LCD_BLON), 32'd1);
    checkOutput("busy during init",       32'(busy_o),   32'd1);
    waitIdle();
    checkOutput("init busy falls", 32'(busy_o), 32'd0);
    checkOutput("init bytes left", 32'(sb.size()), 32'd0);
    checkOutput("init byte count", 32'(falls.size()), 32'd4);
    if (falls.size() >= 4) begin
      checkOutput("gap 0x38->0x0C", 32'(falls[1] - falls[0]), 32'd8);
      checkOutput("gap 0x0C->0x01", 32'(falls[2] - falls[1]), 32'd8);
      checkOutput("gap after clear", 32'(falls[3] - falls[2]), 32'd12);
    end
    checkOutput("no done during init", 32'(done_cnt), 32'd0);

    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt;
      pushRefresh(vecs[v].text);
      applyStimulus(vecs[v].value);
      checkOutput("busy after sample", 32'(busy_o), 32'd1);
      lat = 0;
      while (!LCD_EN && lat < 100) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checkOutput("first EN rise latency", 32'(lat), 32'd19);
      waitDone(got);
      checkOutput("refresh done seen", 32'(got), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("done one pulse", 32'(done_cnt - d0), 32'd1);
      checkOutput("refresh bytes left", 32'(sb.size()), 32'd0);
    end

    // Newest pending value wins; exactly one extra refresh follows.
    d0 = done_cnt;
    pushRefresh("00100");
    pushRefresh("00009");
    applyStimulus(16'd100);
    repeat (5) @(posedge clk);
    applyStimulus(16'd7);
    repeat (20) @(posedge clk);
    applyStimulus(16'd9);
    waitDone(got);
    checkOutput("pending first done", 32'(got), 32'd1);
    waitDone(got);
    checkOutput("pending second done", 32'(got), 32'd1);
    repeat (60) @(posedge clk);
    #1;
    checkOutput("pending done count", 32'(done_cnt - d0), 32'd2);
    checkOutput("pending bytes left", 32'(sb.size()), 32'd0);
    checkOutput("idle after pending", 32'(busy_o), 32'd0);

    // Reset while a digit strobe is high.
    d0  = done_cnt;
    nb0 = nbytes;
    pushRefresh("12345");
    applyStimulus(16'd12345);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (nbytes >= nb0 + 2 && LCD_EN) break;
    end
    checkOutput("mid-digit EN high", 32'(LCD_EN), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("EN drops on reset", 32'(LCD_EN), 32'd0);
    checkOutput("busy on reset",     32'(busy_o), 32'd1);
    checkOutput("LCD_ON on reset",   32'(LCD_ON), 32'd0);
    sb.delete();
    pushInit();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    waitIdle();
    checkOutput("reinit busy falls", 32'(busy_o), 32'd0);
    repeat (60) @(posedge clk);
    #1;
    checkOutput("reinit bytes left",  32'(sb.size()), 32'd0);
    checkOutput("no digits after reset", 32'(nbytes - nb0), 32'd6);
    checkOutput("no done after reset", 32'(done_cnt - d0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
